key_sched_decr: RTL and testbench
=================================

KEY_SCHED_DECR -- requirements
Module: key_sched_decr

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port cipher_key, input, 128 bits: AES-128 cipher key; byte 0 at bits [127:120]; word 0 at bits [127:96].
REQ-004 SHALL have port key_valid, input, 1 bit: cipher_key is offered.
REQ-005 SHALL have port key_ready, output, 1 bit: the block can accept a key.
REQ-006 SHALL have port rk_out, output, 128 bits: round key, in the same byte layout as the state words fed to add-round-key.
REQ-007 SHALL have port rk_index, output, 4 bits: round number of rk_out (10 down to 0).
REQ-008 SHALL have port rk_valid, output, 1 bit: rk_out and rk_index are valid.
REQ-009 SHALL have port rk_ready, input, 1 bit: the consumer accepts rk_out.
REQ-010 SHALL have port rk_last, output, 1 bit: high with rk_valid when rk_index is 0.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement three states: IDLE, EXPAND and EMIT.
REQ-013 SHALL drive key_ready high only in IDLE.
REQ-014 SHALL, on key_valid && key_ready in cycle T, store cipher_key as rk[0] and enter EXPAND.
REQ-015 SHALL, in EXPAND, compute one round key per cycle, rk[1]..rk[10], during cycles T+1..T+10, using the FIPS-197 schedule: RotWord, SubWord and Rcon.
REQ-016 SHALL use the Rcon sequence 01,02,04,08,10,20,40,80,1B,36 (placed in the MSB byte), driven by a 4-bit round counter.
REQ-017 SHALL store all 11 round keys in an internal 11x128 register buffer.
REQ-018 SHALL enter EMIT after rk[10] is written and assert rk_valid from cycle T+11, with rk_out=rk[10] and rk_index=10.
REQ-019 SHALL, in EMIT, advance rk_index by -1 on each rk_valid && rk_ready; rk_out, rk_index and rk_last SHALL hold stable while rk_valid && !rk_ready.
REQ-020 SHALL, on the handshake of rk_index 0, deassert rk_valid in the next cycle and return to IDLE.
REQ-021 SHALL ignore key_valid outside IDLE; the internal buffer SHALL NOT change while in EMIT.
REQ-022 SHALL drive rk_out to zero whenever rk_valid is low.

Reset
REQ-023 SHALL, while rst is high, force state=IDLE, rk_valid=0, rk_last=0, busy=0, key_ready=1, rk_index=0, rk_out=0 and round counter=0, regardless of the clock.
REQ-024 SHALL, on reset asserted mid-EXPAND or mid-EMIT, abandon the operation; the buffer is not cleared, and no stale key is emitted until a new key is accepted.

Configuration
REQ-025 SHALL, with KEY_SCHED_REPLAY_EN defined, add input port replay (1 bit). replay high in IDLE, after at least one complete emission, re-enters EMIT at rk_index 10 without re-expansion, in the next cycle. If replay and key_valid are both high in IDLE, key_valid wins.
REQ-026 SHALL, without KEY_SCHED_REPLAY_EN, have no replay port; each emission requires a new key.

Structure
REQ-027 SHALL take the shared AES package constants (NUM_ROUNDS=10, KEY_W=128, the Rcon table and the state-encoding typedef) from the package shared with the encryption side.
REQ-028 SHALL instantiate sub-module aes_sbox (the combinational forward S-box, 8-bit in and 8-bit out) four times for SubWord.

Verification
REQ-029 SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> first output d014f9a8c9ee2589e13f0cc8b6630ca6 at rk_index 10, exactly 11 cycles after the key handshake; last output equals the key, with rk_last=1.
REQ-030 SHALL cover: all-zero key -> rk_index 10 gives b4ef5bcb3e92e21123e951cf6f8f188e, and rk_index 1 gives 62636363626363636263636362636363.
REQ-031 SHALL cover: rk_ready held low for 5 cycles at rk_index 7 -> rk_out, rk_index and rk_valid stable for all 5 cycles, then rk_index 6 follows.
REQ-032 SHALL cover: rst pulsed at T+5 -> busy=0, key_ready=1 and rk_valid=0 immediately; a new key then emits its correct keys only.
REQ-033 SHALL cover: key_valid with a different key during EMIT -> ignored, and the emitted sequence is unchanged.
REQ-034 SHALL cover, with KEY_SCHED_REPLAY_EN: replay after a complete emission -> an identical 11-key sequence starts at rk_index 10 in the next cycle.

Source files
------------

// File: rtl/key_sched_decr_pkg.sv
// -----------------------------------------------------------------------------
// key_sched_decr_pkg
// Shared AES-128 constants used by both the encryption and decryption sides:
// round count, key width, the round-constant table and the key-schedule
// state encoding.
// -----------------------------------------------------------------------------
package key_sched_decr_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;
    localparam int RK_IDX_W   = 4;

    // Round constants for rounds 1..10, stored at index round-1.
    localparam logic [7:0] RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } sched_state_e;

    // RotWord: cyclic left rotation of a 32-bit word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_sched_decr_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box.
// Ports:
//   in_byte  - byte to substitute
//   out_byte - substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_sched_decr.sv
// -----------------------------------------------------------------------------
// key_sched_decr
// AES-128 key schedule for the decryption side. A key is expanded into all
// eleven round keys (one per cycle), which are then emitted last-first
// (round 10 down to round 0) over a valid/ready handshake.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   cipher_key      - AES-128 key, byte 0 at [127:120]
//   key_valid       - cipher_key offered
//   key_ready       - key can be accepted (IDLE only)
//   replay          - (KEY_SCHED_REPLAY_EN only) re-emit the last expanded key
//   rk_out          - round key, zero whenever rk_valid is low
//   rk_index        - round number of rk_out (10 down to 0)
//   rk_valid        - rk_out / rk_index valid
//   rk_ready        - consumer accepts rk_out
//   rk_last         - rk_valid with rk_index 0
//   busy            - not IDLE
//
// Build option: define KEY_SCHED_REPLAY_EN to add the replay input.
// -----------------------------------------------------------------------------
module key_sched_decr
    import key_sched_decr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    cipher_key,
    input  logic                key_valid,
    output logic                key_ready,
`ifdef KEY_SCHED_REPLAY_EN
    input  logic                replay,
`endif
    output logic [KEY_W-1:0]    rk_out,
    output logic [RK_IDX_W-1:0] rk_index,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                rk_last,
    output logic                busy
);

    localparam logic [RK_IDX_W-1:0] LAST_ROUND = RK_IDX_W'(NUM_ROUNDS);

    sched_state_e        state_q, state_d;
    logic [RK_IDX_W-1:0] round_q, round_d;   // round key being computed in EXPAND
    logic [RK_IDX_W-1:0] idx_q,   idx_d;     // round key being offered in EMIT
`ifdef KEY_SCHED_REPLAY_EN
    logic                emitted_q, emitted_d; // buffer holds a fully emitted key set
`endif

    logic [KEY_W-1:0]    rk_buf_q [NUM_ROUNDS+1];
    logic                buf_we;
    logic [RK_IDX_W-1:0] buf_widx;
    logic [KEY_W-1:0]    buf_wdata;

    // -------------------------------------------------------------------------
    // One FIPS-197 expansion step: rk[round] from rk[round-1]
    // -------------------------------------------------------------------------
    logic [RK_IDX_W-1:0] prev_idx;
    logic [KEY_W-1:0]    prev_rk;
    logic [KEY_W-1:0]    next_rk;
    logic [31:0]         rot_w;
    logic [31:0]         sub_w;
    logic [31:0]         temp_w;
    logic [31:0]         nw0, nw1, nw2, nw3;

    // round_q is 0 outside EXPAND; clamp so the read stays in range.
    assign prev_idx = (round_q == '0) ? '0 : round_q - 1'b1;
    assign prev_rk  = rk_buf_q[prev_idx];
    assign rot_w    = rot_word(prev_rk[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*i +: 8]),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    assign temp_w  = sub_w ^ {RCON[prev_idx], 24'h0};
    assign nw0     = prev_rk[127:96] ^ temp_w;
    assign nw1     = prev_rk[95:64]  ^ nw0;
    assign nw2     = prev_rk[63:32]  ^ nw1;
    assign nw3     = prev_rk[31:0]   ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        idx_d     = idx_q;
        buf_we    = 1'b0;
        buf_widx  = round_q;
        buf_wdata = next_rk;
`ifdef KEY_SCHED_REPLAY_EN
        emitted_d = emitted_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    buf_we    = 1'b1;
                    buf_widx  = '0;
                    buf_wdata = cipher_key;
                    round_d   = RK_IDX_W'(1);
                    state_d   = EXPAND;
`ifdef KEY_SCHED_REPLAY_EN
                    emitted_d = 1'b0;
                end else if (replay && emitted_q) begin
                    idx_d     = LAST_ROUND;
                    state_d   = EMIT;
`endif
                end
            end
            EXPAND: begin
                buf_we = 1'b1;
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    idx_d   = LAST_ROUND;
                    state_d = EMIT;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == '0) begin
                        state_d   = IDLE;
`ifdef KEY_SCHED_REPLAY_EN
                        emitted_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            round_q   <= '0;
            idx_q     <= '0;
`ifdef KEY_SCHED_REPLAY_EN
            emitted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            idx_q     <= idx_d;
`ifdef KEY_SCHED_REPLAY_EN
            emitted_q <= emitted_d;
`endif
        end
    end

    // NOTE: the round-key buffer has no reset; nothing reads it until a new
    // key has been accepted and expanded, and the reset of the control state
    // already guarantees that.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            rk_buf_q[buf_widx] <= buf_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = (state_q == EMIT);
    assign rk_index  = idx_q;
    assign rk_last   = rk_valid && (idx_q == '0);
    assign rk_out    = rk_valid ? rk_buf_q[idx_q] : '0;

endmodule

// File: tb/tb_key_sched_decr.sv
// -----------------------------------------------------------------------------
// tb_key_sched_decr
// Self-checking bench for key_sched_decr. Expected round keys come from a
// word-level FIPS-197 expansion whose S-box is derived from GF(2^8)
// inversion plus the affine transform, and from published key vectors.
// Define KEY_SCHED_REPLAY_EN to also exercise the replay input.
// -----------------------------------------------------------------------------
module tb_key_sched_decr;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] cipher_key;
    logic         key_valid;
    logic         key_ready;
`ifdef KEY_SCHED_REPLAY_EN
    logic         replay;
`endif
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;

    always #5 clk = ~clk;

    key_sched_decr dut (
        .clk        (clk),
        .rst        (rst),
        .cipher_key (cipher_key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
`ifdef KEY_SCHED_REPLAY_EN
        .replay     (replay),
`endif
        .rk_out     (rk_out),
        .rk_index   (rk_index),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_last    (rk_last),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [7:0]   sbox_m   [256];
    logic [127:0] model_rk [11];
    logic [127:0] got_rk   [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------------------------------------------------------- tasks
    // Offers a key and waits (bounded) for the first round key; the first
    // rk_valid must appear 11 cycles after the handshake cycle.
    task automatic send_key(input logic [127:0] key, input string tag);
        int cyc;
        @(negedge clk);
        check({tag, " key_ready"}, key_ready, 1'b1);
        cipher_key = key;
        key_valid  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                key_valid = 1'b0;
                check({tag, " busy expand"}, busy, 1'b1);
                check({tag, " key_ready expand"}, key_ready, 1'b0);
                check({tag, " rk_valid expand"}, rk_valid, 1'b0);
                check({tag, " rk_out expand"}, rk_out, 128'h0);
            end
        end while (!rk_valid && cyc < 30);
        check({tag, " latency"}, 128'(cyc), 128'd11);
    endtask

    // Walks indices 10..0 checking each against the model, optionally
    // stalling at one index and offering a foreign key during EMIT.
    task automatic drain(input string tag, input int stall_at, input int stall_len, input bit inject);
        for (int i = 10; i >= 0; i--) begin
            check({tag, " valid"}, rk_valid, 1'b1);
            check({tag, " index"}, rk_index, 128'(i));
            check({tag, " rk_out"}, rk_out, model_rk[i]);
            check({tag, " last"}, rk_last, (i == 0));
            got_rk[i] = rk_out;
            if (inject && i == 8) begin
                cipher_key = ~cipher_key;
                key_valid  = 1'b1;
            end
            if (inject && i == 0) key_valid = 1'b0;
            if (i == stall_at) begin
                rk_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check({tag, " stall valid"}, rk_valid, 1'b1);
                    check({tag, " stall index"}, rk_index, 128'(i));
                    check({tag, " stall rk_out"}, rk_out, model_rk[i]);
                    check({tag, " stall last"}, rk_last, (i == 0));
                end
                rk_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, " end valid"}, rk_valid, 1'b0);
        check({tag, " end busy"}, busy, 1'b0);
        check({tag, " end key_ready"}, key_ready, 1'b1);
        check({tag, " end rk_out"}, rk_out, 128'h0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, " rst busy"}, busy, 1'b0);
        check({tag, " rst key_ready"}, key_ready, 1'b1);
        check({tag, " rst rk_valid"}, rk_valid, 1'b0);
        check({tag, " rst rk_last"}, rk_last, 1'b0);
        check({tag, " rst rk_index"}, rk_index, 128'h0);
        check({tag, " rst rk_out"}, rk_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // No stale emission may follow a reset (replay is tried too when present).
    task automatic expect_quiet(input string tag);
        int seen;
        seen = 0;
`ifdef KEY_SCHED_REPLAY_EN
        replay = 1'b1;
`endif
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rk_valid || busy) seen++;
        end
`ifdef KEY_SCHED_REPLAY_EN
        replay = 1'b0;
`endif
        check({tag, " quiet after reset"}, 128'(seen), 128'd0);
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rkey;

        vecs[0] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{FIPS_KEY,  9, 128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{FIPS_KEY,  0, FIPS_KEY};
        vecs[3] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[4] = '{128'h0,    1, 128'h62636363626363636263636362636363};
        vecs[5] = '{128'h0,    0, 128'h0};

        rst        = 1'b1;
        key_valid  = 1'b0;
        rk_ready   = 1'b1;
        cipher_key = '0;
`ifdef KEY_SCHED_REPLAY_EN
        replay     = 1'b0;
`endif
        build_sbox();

        #12;
        check("reset busy", busy, 1'b0);
        check("reset key_ready", key_ready, 1'b1);
        check("reset rk_valid", rk_valid, 1'b0);
        check("reset rk_last", rk_last, 1'b0);
        check("reset rk_index", rk_index, 128'h0);
        check("reset rk_out", rk_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef KEY_SCHED_REPLAY_EN
        expect_quiet("replay before any emission");
`endif

        // Known-answer vectors.
        for (int v = 0; v < 6; v++) begin
            model_expand(vecs[v].key);
            send_key(vecs[v].key, "vec");
            drain("vec", -1, 0, 1'b0);
            check($sformatf("vec%0d idx%0d", v, vecs[v].idx), got_rk[vecs[v].idx], vecs[v].exp);
        end

        // Backpressure: rk_ready low for 5 cycles at index 7.
        model_expand(FIPS_KEY);
        send_key(FIPS_KEY, "stall");
        drain("stall", 7, 5, 1'b0);

        // Foreign key offered during EMIT must be ignored.
        send_key(FIPS_KEY, "inject");
        drain("inject", -1, 0, 1'b1);

`ifdef KEY_SCHED_REPLAY_EN
        // Replay re-emits the identical sequence starting next cycle.
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        check("replay next cycle", rk_valid, 1'b1);
        drain("replay", 3, 2, 1'b0);

        // key_valid wins over replay.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        model_expand(rkey);
        replay = 1'b1;
        send_key(rkey, "replay+key");
        replay = 1'b0;
        drain("replay+key", -1, 0, 1'b0);
`endif

        // Reset mid-EXPAND (handshake cycle T, reset at T+5).
        rkey = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        cipher_key = rkey;
        key_valid  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        pulse_reset("mid-expand");
        expect_quiet("mid-expand");
        rkey = {$urandom, $urandom, $urandom, $urandom};
        model_expand(rkey);
        send_key(rkey, "after expand reset");
        drain("after expand reset", -1, 0, 1'b0);

        // Reset mid-EMIT.
        send_key(rkey, "mid-emit");
        repeat (3) @(negedge clk);
        pulse_reset("mid-emit");
        expect_quiet("mid-emit");
        model_expand(FIPS_KEY);
        send_key(FIPS_KEY, "after emit reset");
        drain("after emit reset", -1, 0, 1'b0);

        // Randomized keys and backpressure against the model.
        for (int n = 0; n < 8; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            send_key(rkey, "rnd");
            drain("rnd", int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), n[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
